riscv_prog_loader: RTL and testbench

// - Writer side of the CPU instruction/data memory: receives a program as a byte stream and writes it into the memory the pipeline fetches from.
// - Frame format: 2-byte big-endian word count N, then 4*N data bytes, then 1 XOR checksum byte.
// - Each data word is 4 bytes, big-endian: first byte goes to [31:24].
// - After a good frame it asserts cpu_run, which releases the CPU from hold.

---
 rtl/riscv_pkg.sv | 28 ++
 rtl/riscv_prog_loader_if.sv | 22 ++
 rtl/riscv_byte_packer.sv | 33 +++
 rtl/riscv_prog_loader.sv | 148 ++++++++++++++
 tb/tb_riscv_prog_loader.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the CPU and its program loader: opcodes, the HLT
// word both ends agree on, and the loader state encoding.
package riscv_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b000011;
  localparam logic [5:0] OP_BEQZ = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_HLT  = 6'b111111;

  localparam logic [31:0] HLT_WORD = {OP_HLT, 26'd0};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_DATA,
    ST_CSUM,
    ST_HLT_WR,
    ST_DONE,
    ST_ERR
  } loader_state_t;

endpackage

// File: rtl/riscv_prog_loader_if.sv
// Byte-stream input and memory write port of the program loader.
// master = stream source / memory side, slave = the loader.
interface riscv_prog_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/riscv_byte_packer.sv
// Assembles big-endian 32-bit words from a byte stream. word_valid is high
// in the cycle the 4th byte of a word is presented, with the complete word.
module riscv_byte_packer (
  input  logic        clk1,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);
  logic [1:0]  idx;
  logic [23:0] shreg;

  assign word_valid = byte_valid && (idx == 2'd3);
  assign word       = {shreg, byte_data};

  // Byte index and the three earlier bytes of the word being assembled.
  always_ff @(posedge clk1 or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create ordering-dependent logic.
    if (rst) begin
      idx   <= 2'd0;
      shreg <= 24'd0;
    end else if (clear) begin
      idx   <= 2'd0;
      shreg <= 24'd0;
    end else if (byte_valid) begin
      idx   <= idx + 2'd1;
      shreg <= {shreg[15:0], byte_data};
    end
  end
endmodule

// File: rtl/riscv_prog_loader.sv
// Program loader: parses a framed byte stream (16-bit word count, words,
// XOR checksum), writes the words into CPU memory, optionally appends HLT,
// and releases the CPU with cpu_run once the checksum matches.
module riscv_prog_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_WORDS  = 1024,
  parameter int APPEND_HLT = 1
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start,
  riscv_prog_loader_if.slave bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_run,
  output logic [ADDR_W:0]   words_loaded
);
  localparam int MEM_WORDS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  loader_state_t state;
  logic [15:0]   n_words;
  logic [7:0]    csum_acc;

  logic          accept;
  logic          restart;
  logic [15:0]   n_full;
  logic          hdr_bad;
  logic          last_word;
  logic          word_valid;
  logic [31:0]   word;

  assign accept    = bus.in_valid && bus.in_ready;
  assign restart   = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
  assign n_full    = {n_words[15:8], bus.in_data};
  assign hdr_bad   = (int'(n_full) > MAX_WORDS) ||
                     ((BASE_ADDR + int'(n_full) + APPEND_HLT) > MEM_WORDS);
  assign last_word = (16'(words_loaded) + 16'd1) == n_words;

  riscv_byte_packer u_packer (
    .clk1       (clk1),
    .rst        (rst),
    .clear      (restart),
    .byte_valid (accept && state == ST_DATA),
    .byte_data  (bus.in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Frame FSM with registered stream, memory and status outputs.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      // NOTE: the target memory lives outside this block, so reset leaves the
      // already-loaded words intact; only the loader's own registers clear.
      state        <= ST_IDLE;
      n_words      <= 16'd0;
      csum_acc     <= 8'd0;
      bus.in_ready <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= 32'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_run      <= 1'b0;
      words_loaded <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      if (accept) csum_acc <= csum_acc ^ bus.in_data;

      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state        <= ST_HDR_HI;
            busy         <= 1'b1;
            bus.in_ready <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_run      <= 1'b0;
            words_loaded <= '0;
            csum_acc     <= 8'd0;
          end
        end
        ST_HDR_HI: begin
          if (accept) begin
            n_words[15:8] <= bus.in_data;
            state         <= ST_HDR_LO;
          end
        end
        ST_HDR_LO: begin
          if (accept) begin
            n_words[7:0] <= bus.in_data;
            if (hdr_bad) begin
              state        <= ST_ERR;
              error        <= 1'b1;
              busy         <= 1'b0;
              bus.in_ready <= 1'b0;
            end else if (n_full == 16'd0) begin
              state <= ST_CSUM;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_valid) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= BASE + words_loaded[ADDR_W-1:0];
            bus.mem_wdata <= word;
            words_loaded  <= words_loaded + 1'b1;
            if (last_word) state <= ST_CSUM;
          end
        end
        ST_CSUM: begin
          if (accept) begin
            bus.in_ready <= 1'b0;
            if (bus.in_data != csum_acc) begin
              state <= ST_ERR;
              error <= 1'b1;
              busy  <= 1'b0;
            end else if (APPEND_HLT != 0) begin
              state         <= ST_HLT_WR;
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= BASE + n_words[ADDR_W-1:0];
              bus.mem_wdata <= HLT_WORD;
            end else begin
              state   <= ST_DONE;
              done    <= 1'b1;
              cpu_run <= 1'b1;
              busy    <= 1'b0;
            end
          end
        end
        ST_HLT_WR: begin
          state   <= ST_DONE;
          done    <= 1'b1;
          cpu_run <= 1'b1;
          busy    <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_prog_loader.sv
// Self-checking bench for riscv_prog_loader: directed frames from the frame
// rules plus random frames, compared against a frame-level reference model.
module tb_riscv_prog_loader;
  localparam int ADDR_W = 10;

  logic              clk1;
  logic              rst;
  logic              start;
  logic              busy, done, error, cpu_run;
  logic [ADDR_W:0]   words_loaded;

  riscv_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  riscv_prog_loader #(
    .ADDR_W(ADDR_W), .BASE_ADDR(0), .MAX_WORDS(1024), .APPEND_HLT(1)
  ) dut (
    .clk1         (clk1),
    .rst          (rst),
    .start        (start),
    .bus          (bus.slave),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .cpu_run      (cpu_run),
    .words_loaded (words_loaded)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int tests = 0;
  int fails = 0;

  logic [41:0] got_q[$];
  logic [41:0] exp_q[$];
  logic [7:0]  frame_q[$];
  logic        exp_done, exp_err;
  int          exp_wl;

  // Every cycle with mem_we high is one write; a stretched strobe shows up as an extra entry.
  always @(negedge clk1) begin
    if (bus.mem_we === 1'b1) got_q.push_back({bus.mem_addr, bus.mem_wdata});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: what the frame in frame_q must produce.
  task automatic model();
    int n;
    logic [7:0] x;
    n = int'({frame_q[0], frame_q[1]});
    exp_q.delete();
    exp_wl   = 0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (n > 1024 || n + 1 > 1024) begin
      exp_err = 1'b1;
      return;
    end
    x = 8'd0;
    for (int i = 0; i < 2 + 4 * n; i++) x ^= frame_q[i];
    for (int w = 0; w < n; w++)
      exp_q.push_back({10'(w), frame_q[2+4*w], frame_q[3+4*w], frame_q[4+4*w], frame_q[5+4*w]});
    exp_wl = n;
    if (frame_q[2+4*n] == x) begin
      exp_q.push_back({10'(n), 32'hFC000000});
      exp_done = 1'b1;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  task automatic build_random(input int n, input bit corrupt);
    logic [7:0] x, b;
    frame_q.delete();
    frame_q.push_back(8'(n >> 8));
    frame_q.push_back(8'(n));
    x = frame_q[0] ^ frame_q[1];
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      frame_q.push_back(b);
      x ^= b;
    end
    if (corrupt) x ^= 8'($urandom_range(1, 255));
    frame_q.push_back(x);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 2);
      repeat (g) begin
        bus.in_valid = 1'b0;
        @(negedge clk1);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk1);
      t++;
    end
    if (t >= 50) check("in_ready_timeout", bus.in_ready, 1);
    else @(negedge clk1);
  endtask

  task automatic run_frame(input bit gaps, input bit pulse_start);
    got_q.delete();
    start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
    foreach (frame_q[i]) begin
      if (pulse_start && i == 4) start = 1'b1;
      send_byte(frame_q[i], gaps);
      start = 1'b0;
    end
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk1);
  endtask

  task automatic compare(input string name);
    int m;
    model();
    check($sformatf("%s.num_writes", name), got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check($sformatf("%s.write%0d", name, i), got_q[i], exp_q[i]);
    check($sformatf("%s.done", name), done, exp_done);
    check($sformatf("%s.cpu_run", name), cpu_run, exp_done);
    check($sformatf("%s.error", name), error, exp_err);
    check($sformatf("%s.words_loaded", name), words_loaded, exp_wl);
    check($sformatf("%s.busy", name), busy, 0);
    check($sformatf("%s.in_ready", name), bus.in_ready, 0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".busy"}, busy, 0);
    check({name, ".done"}, done, 0);
    check({name, ".error"}, error, 0);
    check({name, ".cpu_run"}, cpu_run, 0);
    check({name, ".words_loaded"}, words_loaded, 0);
    check({name, ".in_ready"}, bus.in_ready, 0);
    check({name, ".mem_we"}, bus.mem_we, 0);
    check({name, ".mem_addr"}, bus.mem_addr, 0);
    check({name, ".mem_wdata"}, bus.mem_wdata, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    @(negedge clk1);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk1);

    // Directed two-word frame with good checksum (0x92).
    frame_q = '{8'h00, 8'h02, 8'h8C, 8'h20, 8'h00, 8'h10, 8'h28, 8'h01, 8'h00, 8'h05, 8'h92};
    run_frame(1'b0, 1'b0);
    compare("good2");
    check("good2.word0_literal", got_q.size() > 0 ? got_q[0] : 42'd0, {10'd0, 32'h8C200010});

    // Same frame, wrong checksum.
    frame_q[10] = 8'h93;
    run_frame(1'b0, 1'b0);
    compare("badcsum");

    // N = 1025: rejected after the header, nothing more accepted.
    frame_q = '{8'h04, 8'h01};
    run_frame(1'b0, 1'b0);
    compare("n1025");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    repeat (3) @(negedge clk1);
    check("n1025.in_ready_held", bus.in_ready, 0);
    check("n1025.no_writes", got_q.size(), 0);
    bus.in_valid = 1'b0;

    // N = 1024 leaves no room for HLT.
    frame_q = '{8'h04, 8'h00};
    run_frame(1'b0, 1'b0);
    compare("n1024");

    // Empty program: only HLT at address 0.
    frame_q = '{8'h00, 8'h00, 8'h00};
    run_frame(1'b0, 1'b0);
    compare("n0");

    // Random frames, gappy stream, start pulsed mid-frame.
    for (int k = 0; k < 6; k++) begin
      build_random($urandom_range(1, 6), (k == 2 || k == 5));
      run_frame(1'b1, 1'b1);
      compare($sformatf("rand%0d", k));
    end

    // Largest program that still fits HLT.
    build_random(1023, 1'b0);
    run_frame(1'b0, 1'b0);
    compare("n1023");

    // Reset after 6 data bytes, then a full reload.
    build_random(2, 1'b0);
    got_q.delete();
    start = 1'b1;
    @(negedge clk1);
    start = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(frame_q[i], 1'b0);
    bus.in_valid = 1'b0;
    check("midrst.wl_before", words_loaded, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk1);
    rst = 1'b0;
    @(negedge clk1);
    run_frame(1'b1, 1'b0);
    compare("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
